// File: rtl/aes_dec_stream_ctrl.sv
`timescale 1ns/1ps
// Purpose: key-expansion sequencer plus credit-throttled stream wrapper around the non-stalling pipelined AES_dec core.
// Latency: accept -> core_enable one cycle; core_valid_out -> m_valid one cycle; key_load -> key_ack one cycle (after drain).
// Backpressure: s_ready drops while in_flight + fifo_count reaches OUT_DEPTH, so every in-flight core result has a FIFO slot.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   key_in/key_load/key_ack  key change request (level) and 1-cycle capture pulse
//   key_ready                round keys valid, streaming enabled
//   s_valid/s_ready/s_data   ciphertext input handshake
//   m_valid/m_ready/m_data   plaintext output handshake (FIFO head, first-word-fall-through)
//   core_*                   connections to AES_dec (KEY, fsm_en, IN, enable, OUT, valid_out)
//   err                      sticky: FIFO overflow or core_valid_out with nothing in flight
module aes_dec_stream_ctrl #(
    parameter int DATA_W         = 128,
    parameter int KEY_EXP_CYCLES = 11,
    parameter int OUT_DEPTH      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] key_in,
    input  logic              key_load,
    output logic              key_ack,
    output logic              key_ready,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [DATA_W-1:0] core_key,
    output logic              core_fsm_en,
    output logic [DATA_W-1:0] core_in,
    output logic              core_enable,
    input  logic [DATA_W-1:0] core_out,
    input  logic              core_valid_out,
    output logic              err
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = (KEY_EXP_CYCLES > 1) ? $clog2(KEY_EXP_CYCLES) : 1;

    localparam logic [EW-1:0] LP_EXP_LAST = EW'(KEY_EXP_CYCLES - 1);
    localparam logic [CW:0]   LP_DEPTH_S  = (CW + 1)'(OUT_DEPTH);
    localparam logic [CW-1:0] LP_DEPTH_C  = CW'(OUT_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXP,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            r_state;
    logic [EW-1:0]     r_exp_cnt;
    logic              r_key_ack;
    logic              r_key_ready;
    logic              r_fsm_en;
    logic [DATA_W-1:0] r_core_key;
    logic [DATA_W-1:0] r_core_in;
    logic              r_core_enable;
    logic [CW-1:0]     r_in_flight;
    logic [CW-1:0]     r_fifo_cnt;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [OUT_DEPTH];

    logic [CW:0] w_credit_sum;
    logic        w_s_ready;
    logic        w_accept;
    logic        w_ret_ok;
    logic        w_ret_stale;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf;

    // Credit covers both buffered results and results still inside the core,
    // because the core cannot be stalled once a block has entered it.
    assign w_credit_sum = {1'b0, r_in_flight} + {1'b0, r_fifo_cnt};
    assign w_s_ready    = (r_state == S_RUN) && !key_load && (w_credit_sum < LP_DEPTH_S);
    assign w_accept     = s_valid && w_s_ready;

    // A result with nothing in flight can only be a leftover from before reset.
    assign w_ret_ok     = core_valid_out && (r_in_flight != '0);
    assign w_ret_stale  = core_valid_out && (r_in_flight == '0);

    assign w_full  = (r_fifo_cnt == LP_DEPTH_C);
    assign w_empty = (r_fifo_cnt == '0);
    assign w_pop   = !w_empty && m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
    assign w_push  = w_ret_ok && (!w_full || w_pop);
    assign w_ovf   = w_ret_ok && w_full && !w_pop;

    // Key sequencing FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_exp_cnt   <= '0;
            r_key_ack   <= 1'b0;
            r_key_ready <= 1'b0;
            r_fsm_en    <= 1'b0;
            r_core_key  <= '0;
        end else begin
            r_key_ack <= 1'b0;
            r_fsm_en  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (key_load) begin
                        r_state    <= S_LOAD;
                        r_core_key <= key_in;
                        r_key_ack  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state   <= S_EXP;
                    r_fsm_en  <= 1'b1;
                    r_exp_cnt <= '0;
                end
                S_EXP: begin
                    // Count starts on the fsm_en cycle; round keys valid after the last count.
                    if (r_exp_cnt == LP_EXP_LAST) begin
                        r_state     <= S_RUN;
                        r_key_ready <= 1'b1;
                    end else begin
                        r_exp_cnt <= r_exp_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (key_load) begin
                        r_state     <= S_DRAIN;
                        r_key_ready <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // Old-key results must all leave the core before the key changes.
                    if (r_in_flight == '0) begin
                        r_state    <= S_LOAD;
                        r_core_key <= key_in;
                        r_key_ack  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Core feed, in-flight credit, FIFO pointers and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_in     <= '0;
            r_core_enable <= 1'b0;
            r_in_flight   <= '0;
            r_fifo_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_err         <= 1'b0;
        end else begin
            r_core_enable <= w_accept;
            r_core_in     <= w_accept ? s_data : '0;

            case ({w_accept, w_ret_ok})
                2'b10:   r_in_flight <= r_in_flight + 1'b1;
                2'b01:   r_in_flight <= r_in_flight - 1'b1;
                default: r_in_flight <= r_in_flight;
            endcase

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            if (w_ret_stale || w_ovf) begin
                r_err <= 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= core_out;
        end
    end

    assign key_ack     = r_key_ack;
    assign key_ready   = r_key_ready;
    assign s_ready     = w_s_ready;
    assign m_valid     = !w_empty;
    assign m_data      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign core_key    = r_core_key;
    assign core_fsm_en = r_fsm_en;
    assign core_in     = r_core_in;
    assign core_enable = r_core_enable;
    assign err         = r_err;

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
`timescale 1ns/1ps
// Purpose: directed bench for aes_dec_stream_ctrl with a fixed-latency, non-resettable AES_dec stand-in.
// Latency: stand-in core returns each block LAT cycles after core_enable.
// Backpressure: bench drives m_ready per scenario; inputs change on the falling edge.
module tb_aes_dec_stream_ctrl;

    localparam int DW  = 128;
    localparam int LAT = 12;

    localparam logic [DW-1:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [DW-1:0] KEY1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [DW-1:0] CT0  = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [DW-1:0] PT0  = 128'h00112233445566778899AABBCCDDEEFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] key_in;
    logic          key_load;
    logic          key_ack;
    logic          key_ready;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [DW-1:0] core_key;
    logic          core_fsm_en;
    logic [DW-1:0] core_in;
    logic          core_enable;
    logic [DW-1:0] core_out;
    logic          core_valid_out;
    logic          err;

    always #5 clk = ~clk;

    aes_dec_stream_ctrl #(
        .DATA_W         (DW),
        .KEY_EXP_CYCLES (11),
        .OUT_DEPTH      (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key_in         (key_in),
        .key_load       (key_load),
        .key_ack        (key_ack),
        .key_ready      (key_ready),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .core_key       (core_key),
        .core_fsm_en    (core_fsm_en),
        .core_in        (core_in),
        .core_enable    (core_enable),
        .core_out       (core_out),
        .core_valid_out (core_valid_out),
        .err            (err)
    );

    // Stand-in decrypt: the FIPS-197 pair is exact, anything else gets a fixed mask.
    function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] c);
        return (c == CT0) ? PT0 : (c ^ {4{32'hA5C3_5A3C}});
    endfunction

    // Stand-in core pipeline; deliberately not reset, like the real core.
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0]  pd [LAT];
    always @(posedge clk) begin
        pv    <= {pv[LAT-2:0], core_enable};
        pd[0] <= core_fn(core_in);
        for (int i = LAT - 1; i > 0; i--) pd[i] <= pd[i-1];
    end
    assign core_valid_out = pv[LAT-1];
    assign core_out       = pd[LAT-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] exp_q [$];
    int cyc = 0, n_acc = 0, n_out = 0, n_ack = 0, n_fsm = 0;
    int ack_cyc = -1, fsm_cyc = -1, rdy_cyc = -1;
    int sready_low = 0, mvalid_cnt = 0;
    logic prev_rdy = 1'b0;

    // One clock of observation: called just after the falling edge once inputs are set.
    task automatic step();
        #2;
        if (key_ack)     begin n_ack++; ack_cyc = cyc; end
        if (core_fsm_en) begin n_fsm++; fsm_cyc = cyc; end
        if (key_ready && !prev_rdy) rdy_cyc = cyc;
        prev_rdy = key_ready;
        if (s_valid && !s_ready) sready_low++;
        if (m_valid) mvalid_cnt++;
        if (s_valid && s_ready) begin
            exp_q.push_back(core_fn(s_data));
            n_acc++;
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("m_data_unexpected", m_data, '0);
            else                   chk("m_data", m_data, exp_q.pop_front());
            n_out++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_key_ready"}, 128'(key_ready), '0);
        chk({tag, "_key_ack"},   128'(key_ack), '0);
        chk({tag, "_s_ready"},   128'(s_ready), '0);
        chk({tag, "_m_valid"},   128'(m_valid), '0);
        chk({tag, "_m_data"},    m_data, '0);
        chk({tag, "_fsm_en"},    128'(core_fsm_en), '0);
        chk({tag, "_enable"},    128'(core_enable), '0);
        chk({tag, "_core_in"},   core_in, '0);
        chk({tag, "_core_key"},  core_key, '0);
        chk({tag, "_err"},       128'(err), '0);
    endtask

    logic [DW-1:0] vec [11];
    int idx, a0, o0, k0, acc5;

    initial begin
        rst = 1'b1; key_in = '0; key_load = 1'b0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        vec[0] = CT0;
        for (int i = 1; i < 11; i++) vec[i] = {4{32'h1000_0000 + 32'(i)}} ^ {32'(i), 96'h0};
        repeat (3) @(negedge clk);

        // Reset state
        chk_all_zero("rst");

        // Initial key load and expansion timing
        rst = 1'b0; key_in = KEY0; key_load = 1'b1;
        for (int i = 0; i < 40 && n_ack == 0; i++) step();
        key_load = 1'b0;
        for (int i = 0; i < 40 && rdy_cyc < 0; i++) step();
        chk("t1_ack_count", 128'(n_ack), 128'd1);
        chk("t1_fsm_en_count", 128'(n_fsm), 128'd1);
        chk("t1_ack_to_fsm_en", 128'(fsm_cyc - ack_cyc), 128'd1);
        chk("t1_fsm_en_to_ready", 128'(rdy_cyc - fsm_cyc), 128'd11);
        chk("t1_core_key", core_key, KEY0);
        chk("t1_key_ready", 128'(key_ready), 128'd1);

        // Single FIPS-197 block
        m_ready = 1'b1; s_valid = 1'b1; s_data = CT0; a0 = n_acc; o0 = n_out;
        for (int i = 0; i < 10 && n_acc == a0; i++) step();
        s_valid = 1'b0;
        for (int i = 0; i < 40 && n_out == o0; i++) step();
        chk("t2_outputs", 128'(n_out - o0), 128'd1);
        chk("t2_err", 128'(err), '0);

        // Eleven blocks back to back with the sink always ready
        idx = 0; sready_low = 0; o0 = n_out;
        s_valid = 1'b1; s_data = vec[0];
        for (int i = 0; i < 40 && idx < 11; i++) begin
            a0 = n_acc;
            step();
            if (n_acc != a0) begin
                idx++;
                if (idx < 11) s_data = vec[idx];
                else          s_valid = 1'b0;
            end
        end
        chk("t3_accepted", 128'(idx), 128'd11);
        chk("t3_sready_drops", 128'(sready_low), '0);
        for (int i = 0; i < 60 && n_out - o0 < 11; i++) step();
        chk("t3_outputs", 128'(n_out - o0), 128'd11);

        // Sink stalled: credit limits acceptance to the FIFO depth
        m_ready = 1'b0; a0 = n_acc; o0 = n_out;
        s_valid = 1'b1; s_data = 128'hC0DE_0000_0000_0000_0000_0000_0000_0000;
        for (int i = 0; i < 40; i++) begin
            idx = n_acc;
            step();
            if (n_acc != idx) s_data = s_data + 128'd1;
        end
        chk("t4_accepted", 128'(n_acc - a0), 128'd16);
        chk("t4_s_ready_low", 128'(s_ready), '0);
        chk("t4_m_valid", 128'(m_valid), 128'd1);
        chk("t4_err", 128'(err), '0);
        s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 60 && n_out - o0 < 16; i++) step();
        chk("t4_outputs", 128'(n_out - o0), 128'd16);
        step();
        chk("t4_drained", 128'(m_valid), '0);

        // Key change with five blocks in flight
        a0 = n_acc;
        s_valid = 1'b1; s_data = 128'h5EED_0000_0000_0000_0000_0000_0000_0001;
        for (int i = 0; i < 20 && n_acc - a0 < 5; i++) begin
            idx = n_acc;
            step();
            if (n_acc != idx) s_data = s_data + 128'd1;
        end
        key_in = KEY1; key_load = 1'b1;
        #1;
        chk("t5_s_ready_on_key_load", 128'(s_ready), '0);
        acc5 = n_acc; o0 = n_out; k0 = n_ack; rdy_cyc = -1; fsm_cyc = -1;
        step();
        chk("t5_key_ready_drain", 128'(key_ready), '0);
        for (int i = 0; i < 60 && n_ack == k0; i++) step();
        chk("t5_old_key_outputs", 128'(n_out - o0), 128'd5);
        chk("t5_no_accept_in_drain", 128'(n_acc - acc5), '0);
        chk("t5_core_key", core_key, KEY1);
        key_load = 1'b0; s_valid = 1'b0;
        for (int i = 0; i < 40 && rdy_cyc < 0; i++) step();
        chk("t5_ack_to_fsm_en", 128'(fsm_cyc - ack_cyc), 128'd1);
        chk("t5_fsm_en_to_ready", 128'(rdy_cyc - fsm_cyc), 128'd11);
        chk("t5_err", 128'(err), '0);

        // Reset with eight blocks in flight; stale results must be flagged and dropped
        m_ready = 1'b0; a0 = n_acc;
        s_valid = 1'b1; s_data = 128'hDEAD_0000_0000_0000_0000_0000_0000_0001;
        for (int i = 0; i < 20 && n_acc - a0 < 8; i++) begin
            idx = n_acc;
            step();
            if (n_acc != idx) s_data = s_data + 128'd1;
        end
        chk("t6_accepted", 128'(n_acc - a0), 128'd8);
        rst = 1'b1; s_valid = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        exp_q.delete();
        step();
        step();
        rst = 1'b0; m_ready = 1'b1; mvalid_cnt = 0;
        for (int i = 0; i < 25; i++) step();
        chk("t6_m_valid_never", 128'(mvalid_cnt), '0);
        chk("t6_err_sticky", 128'(err), 128'd1);
        chk("t6_key_ready", 128'(key_ready), '0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
